multicycle_control: RTL and testbench

Multi-cycle control FSM for the non-pipelined processor. Sequences one instruction at a time through fetch, decode, execute, memory and write-back. Drives the instruction-fetch stage (PC_sel, PC_LdEn, IR_LdEn), the register file, ALU and data memory from the opcode held in the instruction register and the ALU Zero flag. Also counts retired instructions.

---
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control.sv | 157 +++++++++++++++
 tb/tb_multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller and its datapath: IR/flag
// inputs toward the controller, all datapath strobes and selects back out.
interface multicycle_control_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        MEM_Ready;
  logic        PC_sel;
  logic        PC_LdEn;
  logic        IR_LdEn;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic [1:0]  ImmExt;
  logic        MEM_RdEn;
  logic        MEM_WrEn;
  logic        Illegal;

  // Datapath / stimulus side
  modport master (
    output Instr, Zero, MEM_Ready,
    input  PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
    input  ALU_Bin_sel, ALU_func, ImmExt, MEM_RdEn, MEM_WrEn, Illegal
  );

  // Controller side
  modport slave (
    input  Instr, Zero, MEM_Ready,
    output PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
    output ALU_Bin_sel, ALU_func, ImmExt, MEM_RdEn, MEM_WrEn, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences one instruction at a time through
// fetch, decode, execute, memory and write-back, and counts retired
// instructions. Outputs are decoded from state and the IR opcode, so the
// asynchronous reset clears them immediately by forcing IDLE.
module multicycle_control #(
  parameter int unsigned RETIRED_W = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  multicycle_control_if.slave  bus,
  output logic [RETIRED_W-1:0] Retired
);

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;
  localparam logic [5:0] OP_B    = 6'b111111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [RETIRED_W-1:0] r_retired;

  logic [5:0] w_op;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_alu;
  logic       w_is_branch;
  logic [3:0] w_ex_func;
  logic       w_ex_bin;
  logic [1:0] w_ex_imm;

  assign w_op        = bus.Instr[31:26];
  assign w_is_lw     = (w_op == OP_LW);
  assign w_is_sw     = (w_op == OP_SW);
  assign w_is_alu    = (w_op == OP_R)    || (w_op == OP_ADDI) || (w_op == OP_ANDI) ||
                       (w_op == OP_ORI)  || (w_op == OP_LUI);
  assign w_is_branch = (w_op == OP_BEQ)  || (w_op == OP_BNE)  || (w_op == OP_B);

  // ALU operation, B-operand source and immediate extension for the opcode
  always_comb begin
    w_ex_func = 4'b0000;
    w_ex_bin  = 1'b1;
    w_ex_imm  = 2'b00;
    case (w_op)
      OP_R:    begin w_ex_func = bus.Instr[3:0]; w_ex_bin = 1'b0; end
      OP_ANDI: begin w_ex_func = 4'b0010; w_ex_imm = 2'b01; end
      OP_ORI:  begin w_ex_func = 4'b0011; w_ex_imm = 2'b01; end
      OP_LUI:  w_ex_imm = 2'b10;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_next            = r_state;
    bus.PC_sel        = 1'b0;
    bus.PC_LdEn       = 1'b0;
    bus.IR_LdEn       = 1'b0;
    bus.RF_WrEn       = 1'b0;
    bus.RF_WrData_sel = 1'b0;
    bus.RF_B_sel      = 1'b0;
    bus.ALU_Bin_sel   = 1'b0;
    bus.ALU_func      = 4'b0000;
    bus.ImmExt        = 2'b00;
    bus.MEM_RdEn      = 1'b0;
    bus.MEM_WrEn      = 1'b0;
    bus.Illegal       = 1'b0;
    case (r_state)
      IDLE:   w_next = FETCH;
      FETCH: begin
        bus.IR_LdEn = 1'b1;
        w_next      = DECODE;
      end
      DECODE: begin
        if (w_is_branch) begin
          w_next = BRANCH;
        end else if (w_is_alu || w_is_lw || w_is_sw) begin
          w_next = EXEC;
        end else begin
          // Undefined opcode: skip it and move on to the next instruction
          bus.Illegal = 1'b1;
          bus.PC_LdEn = 1'b1;
          w_next      = FETCH;
        end
      end
      EXEC: begin
        bus.ALU_func    = w_ex_func;
        bus.ALU_Bin_sel = w_ex_bin;
        bus.ImmExt      = w_ex_imm;
        w_next          = (w_is_lw || w_is_sw) ? MEM : WB;
      end
      MEM: begin
        if (w_is_lw) begin
          bus.MEM_RdEn = 1'b1;
        end else begin
          bus.MEM_WrEn = 1'b1;
          bus.RF_B_sel = 1'b1;
        end
        if (bus.MEM_Ready) begin
          // A store retires in its last memory cycle; a load still needs WB
          bus.PC_LdEn = w_is_sw;
          w_next      = w_is_lw ? WB : FETCH;
        end
      end
      WB: begin
        bus.RF_WrEn       = 1'b1;
        bus.RF_WrData_sel = w_is_lw;
        bus.PC_LdEn       = 1'b1;
        bus.ALU_func      = w_ex_func;
        bus.ALU_Bin_sel   = w_ex_bin;
        bus.ImmExt        = w_ex_imm;
        w_next            = FETCH;
      end
      BRANCH: begin
        bus.RF_B_sel = 1'b1;
        bus.ALU_func = 4'b0001;
        bus.PC_LdEn  = 1'b1;
        if (w_op == OP_BEQ)      bus.PC_sel = bus.Zero;
        else if (w_op == OP_BNE) bus.PC_sel = ~bus.Zero;
        else                     bus.PC_sel = 1'b1;
        w_next = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  // Retired-instruction counter; illegal opcodes load the PC but do not retire
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                             r_retired <= '0;
    else if (bus.PC_LdEn && !bus.Illegal)   r_retired <= r_retired + RETIRED_W'(1);
  end

  assign Retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. A driver loads a new
// instruction whenever the IR is loaded and pushes its expected outcome;
// a monitor checks each instruction when PC_LdEn marks its completion.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;
  localparam logic [5:0] OP_B    = 6'b111111;

  typedef struct {
    logic [31:0] instr;
    int unsigned w;
    logic        zero;
  } stim_t;

  typedef struct {
    int unsigned cycles;
    logic        pc_sel, illegal, rf_wren, wr_sel, rf_b_sel, bin_sel;
    logic [3:0]  func;
    logic [1:0]  imm;
    int unsigned rd_cyc, wr_cyc;
    logic        has_exec;
    logic [3:0]  ex_func;
    logic        ex_bin;
    logic [1:0]  ex_imm;
    int unsigned ret_before;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  logic [15:0] ret16;
  logic [1:0]  ret2;

  multicycle_control_if ifc ();
  multicycle_control_if ifc2 ();

  assign ifc2.Instr     = ifc.Instr;
  assign ifc2.Zero      = ifc.Zero;
  assign ifc2.MEM_Ready = ifc.MEM_Ready;

  multicycle_control #(.RETIRED_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .bus(ifc.slave), .Retired(ret16)
  );
  multicycle_control #(.RETIRED_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(ifc2.slave), .Retired(ret2)
  );

  always #5 Clk = ~Clk;

  logic [15:0] outs1, outs2;
  assign outs1 = {ifc.PC_sel, ifc.PC_LdEn, ifc.IR_LdEn, ifc.RF_WrEn, ifc.RF_WrData_sel,
                  ifc.RF_B_sel, ifc.ALU_Bin_sel, ifc.ALU_func, ifc.ImmExt,
                  ifc.MEM_RdEn, ifc.MEM_WrEn, ifc.Illegal};
  assign outs2 = {ifc2.PC_sel, ifc2.PC_LdEn, ifc2.IR_LdEn, ifc2.RF_WrEn, ifc2.RF_WrData_sel,
                  ifc2.RF_B_sel, ifc2.ALU_Bin_sel, ifc2.ALU_func, ifc2.ImmExt,
                  ifc2.MEM_RdEn, ifc2.MEM_WrEn, ifc2.Illegal};

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned npop  = 0;
  int unsigned ret_cnt = 0;
  bit          run = 1'b0;
  logic        irld_prev = 1'b0;
  logic        cur_branch = 1'b0;
  int unsigned w_left = 0;
  int unsigned cyc = 0, rd_n = 0, wr_n = 0, ill_n = 0;
  stim_t       dq[$];
  exp_t        sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == OP_R || op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_LUI ||
           op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_BNE || op == OP_B;
  endfunction

  function automatic stim_t mk(input logic [5:0] op, input int unsigned w, input logic z);
    stim_t s;
    s.instr = {op, 26'($urandom)};
    s.w     = w;
    s.zero  = z;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    logic [5:0] op;
    case ($urandom_range(0, 10))
      0: op = OP_R;    1: op = OP_ADDI; 2: op = OP_ANDI; 3: op = OP_ORI;
      4: op = OP_LUI;  5: op = OP_LW;   6: op = OP_SW;   7: op = OP_BEQ;
      8: op = OP_BNE;  9: op = OP_B;
      default: begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
    endcase
    return mk(op, $urandom_range(0, 4), 1'($urandom));
  endfunction

  // Reference outcome of one instruction, from the opcode tables and CPI rules
  function automatic exp_t model(input stim_t s, input int unsigned rb);
    exp_t e;
    logic [5:0] op;
    op = s.instr[31:26];
    e = '{default: '0};
    e.ret_before = rb;
    e.ex_bin = 1'b1;
    case (op)
      OP_R:    begin e.has_exec = 1; e.ex_func = s.instr[3:0]; e.ex_bin = 1'b0; end
      OP_ADDI: e.has_exec = 1;
      OP_ANDI: begin e.has_exec = 1; e.ex_func = 4'b0010; e.ex_imm = 2'b01; end
      OP_ORI:  begin e.has_exec = 1; e.ex_func = 4'b0011; e.ex_imm = 2'b01; end
      OP_LUI:  begin e.has_exec = 1; e.ex_imm = 2'b10; end
      OP_LW, OP_SW: e.has_exec = 1;
      OP_BEQ, OP_BNE, OP_B: begin
        e.cycles = 3; e.rf_b_sel = 1; e.func = 4'b0001;
        e.pc_sel = (op == OP_BEQ) ? s.zero : (op == OP_BNE) ? !s.zero : 1'b1;
      end
      default: begin e.cycles = 2; e.illegal = 1; end
    endcase
    if (op == OP_LW) begin
      e.cycles = 5 + s.w; e.rd_cyc = 1 + s.w; e.rf_wren = 1; e.wr_sel = 1;
      e.func = e.ex_func; e.bin_sel = e.ex_bin; e.imm = e.ex_imm;
    end else if (op == OP_SW) begin
      e.cycles = 4 + s.w; e.wr_cyc = 1 + s.w; e.rf_b_sel = 1;
    end else if (e.has_exec) begin
      e.cycles = 4; e.rf_wren = 1;
      e.func = e.ex_func; e.bin_sel = e.ex_bin; e.imm = e.ex_imm;
    end
    return e;
  endfunction

  // Driver: new instruction after each IR load, memory wait states, Zero noise
  always @(posedge Clk) begin
    #1;
    if (run) begin
      if (irld_prev) begin
        stim_t s;
        exp_t  e;
        s = (dq.size() > 0) ? dq.pop_front() : rnd_stim();
        ifc.Instr     = s.instr;
        ifc.Zero      = s.zero;
        ifc.MEM_Ready = 1'($urandom);
        w_left        = s.w;
        cur_branch    = (s.instr[31:26] == OP_BEQ) || (s.instr[31:26] == OP_BNE) ||
                        (s.instr[31:26] == OP_B);
        e = model(s, ret_cnt);
        sb.push_back(e);
        if (!e.illegal) ret_cnt++;
      end else begin
        if (!cur_branch) ifc.Zero = 1'($urandom);
        if (ifc.MEM_RdEn || ifc.MEM_WrEn) begin
          if (w_left == 0) ifc.MEM_Ready = 1'b1;
          else begin ifc.MEM_Ready = 1'b0; w_left--; end
        end else begin
          ifc.MEM_Ready = 1'($urandom);
        end
      end
    end
  end

  // Monitor: track cycles/strobes per instruction, check on PC_LdEn
  always @(negedge Clk) begin
    if (run) begin
      if (ifc.IR_LdEn) begin cyc = 1; rd_n = 0; wr_n = 0; ill_n = 0; end
      else cyc++;
      if (ifc.MEM_RdEn) rd_n++;
      if (ifc.MEM_WrEn) wr_n++;
      if (ifc.Illegal)  ill_n++;
      if (cyc == 3 && sb.size() > 0 && sb[0].has_exec) begin
        chk("exec_func", 32'(ifc.ALU_func),    32'(sb[0].ex_func));
        chk("exec_bin",  32'(ifc.ALU_Bin_sel), 32'(sb[0].ex_bin));
        chk("exec_imm",  32'(ifc.ImmExt),      32'(sb[0].ex_imm));
        chk("exec_rfb",  32'(ifc.RF_B_sel),    32'd0);
      end
      if (ifc.PC_LdEn) begin
        if (sb.size() == 0) begin
          chk("spurious_pc_lden", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cycles",    32'(cyc),               32'(e.cycles));
          chk("pc_sel",    32'(ifc.PC_sel),        32'(e.pc_sel));
          chk("illegal",   32'(ifc.Illegal),       32'(e.illegal));
          chk("ill_count", 32'(ill_n),             32'(e.illegal));
          chk("rf_wren",   32'(ifc.RF_WrEn),       32'(e.rf_wren));
          chk("wr_sel",    32'(ifc.RF_WrData_sel), 32'(e.wr_sel));
          chk("rf_b_sel",  32'(ifc.RF_B_sel),      32'(e.rf_b_sel));
          chk("bin_sel",   32'(ifc.ALU_Bin_sel),   32'(e.bin_sel));
          chk("alu_func",  32'(ifc.ALU_func),      32'(e.func));
          chk("imm_ext",   32'(ifc.ImmExt),        32'(e.imm));
          chk("rd_cycles", 32'(rd_n),              32'(e.rd_cyc));
          chk("wr_cycles", 32'(wr_n),              32'(e.wr_cyc));
          chk("retired16", 32'(ret16),             32'(16'(e.ret_before)));
          chk("retired2",  32'(ret2),              32'(2'(e.ret_before)));
          npop++;
        end
      end
      irld_prev = ifc.IR_LdEn;
    end
  end

  task automatic wait_pops(input int unsigned n, input int unsigned budget, input string nm);
    bit ok;
    ok = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge Clk);
      if (npop >= n) begin ok = 1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    Reset = 1'b0;
    ifc.Instr = '0; ifc.Zero = 1'b0; ifc.MEM_Ready = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      chk("reset_outs",  32'(outs1), 32'd0);
      chk("reset_outs2", 32'(outs2), 32'd0);
      chk("reset_ret",   32'(ret16), 32'd0);
    end
    Reset = 1'b1;
    #1;
    run = 1'b1;
    chk("idle_irld", 32'(ifc.IR_LdEn), 32'd0);
    @(negedge Clk);
    chk("fetch_irld", 32'(ifc.IR_LdEn), 32'd1);

    dq.push_back(mk(OP_R, 0, 1'b0));
    dq[0].instr = 32'h8000_0001;
    dq.push_back(mk(OP_LW,  3, 1'b0));
    dq.push_back(mk(OP_BEQ, 0, 1'b1));
    dq.push_back(mk(OP_BEQ, 0, 1'b0));
    dq.push_back(mk(OP_BNE, 0, 1'b1));
    dq.push_back(mk(OP_BNE, 0, 1'b0));
    dq.push_back(mk(6'b000000, 0, 1'b0));
    for (int i = 0; i < 60; i++) dq.push_back(rnd_stim());
    wait_pops(67, 3000, "timeout_main");

    // Long store wait, then reset in the middle of it
    dq.push_back(mk(OP_SW, 30, 1'b0));
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge Clk);
      if (wr_n >= 10) begin ok = 1; break; end
    end
    chk("timeout_sw_wait", 32'(ok), 32'd1);
    run = 1'b0;
    #3;
    Reset = 1'b0;
    #1;
    chk("midmem_wren", 32'(ifc.MEM_WrEn), 32'd0);
    chk("midmem_outs", 32'(outs1), 32'd0);
    chk("midmem_ret",  32'(ret16), 32'd0);
    chk("midmem_ret2", 32'(ret2),  32'd0);
    sb.delete(); dq.delete();
    ret_cnt = 0; npop = 0; irld_prev = 1'b0; cur_branch = 1'b0;
    ifc.MEM_Ready = 1'b0;
    for (int i = 0; i < 5; i++) dq.push_back(mk(OP_R, 0, 1'b0));
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    #1;
    run = 1'b1;
    wait_pops(5, 200, "timeout_rtype");
    #1;
    chk("final_ret16", 32'(ret16), 32'd5);
    chk("final_ret2",  32'(ret2),  32'd1);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
